// File: rtl/raster_window.sv
// raster_window: streaming causal-neighbourhood generator.
// For each accepted pixel P at (x,y) presents P with its left (A), upper-left (B),
// up (C) and upper-right (D) neighbours; out-of-image neighbours read as zero.
// One line of history is kept in a column-indexed line buffer.

`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module raster_window #(
    parameter int WIDTH      = `WORD_SIZE,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480,
    parameter int X_BITS     = 10,
    parameter int Y_BITS     = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              sof,
    input  logic [WIDTH-1:0]  d,
    output logic              q_valid,
    output logic [WIDTH-1:0]  P,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic [WIDTH-1:0]  C,
    output logic [WIDTH-1:0]  D,
    output logic [X_BITS-1:0] q_x,
    output logic [Y_BITS-1:0] q_y,
    output logic              frame_done
);

    localparam int unsigned AW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
    localparam logic [X_BITS-1:0] X_LAST = X_BITS'(IMG_WIDTH - 1);
    localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(IMG_HEIGHT - 1);

    // Previous-row pixels, one entry per column
    logic [WIDTH-1:0] line_mem [IMG_WIDTH];

    logic [X_BITS-1:0] x_cnt_q, x_cnt_d;
    logic [Y_BITS-1:0] y_cnt_q, y_cnt_d;
    logic [WIDTH-1:0]  left_q, left_d;
    // up_q holds prev-row pixel at x, upl_q at x-1 (2-deep shift of buffer reads)
    logic [WIDTH-1:0]  up_q, up_d;
    logic [WIDTH-1:0]  upl_q, upl_d;

    logic              q_valid_q, q_valid_d;
    logic              frame_done_q, frame_done_d;
    logic [WIDTH-1:0]  p_out_q, p_out_d;
    logic [WIDTH-1:0]  a_out_q, a_out_d;
    logic [WIDTH-1:0]  b_out_q, b_out_d;
    logic [WIDTH-1:0]  c_out_q, c_out_d;
    logic [WIDTH-1:0]  d_out_q, d_out_d;
    logic [X_BITS-1:0] q_x_q, q_x_d;
    logic [Y_BITS-1:0] q_y_q, q_y_d;

    logic [X_BITS-1:0] x_cur, x_rd;
    logic [Y_BITS-1:0] y_cur;
    logic              x_first, x_last, y_first, y_last;
    logic [WIDTH-1:0]  rd_data;

    // Position, buffer read address, masking and next-state computation
    always_comb begin
        x_cur   = sof ? '0 : x_cnt_q;
        y_cur   = sof ? '0 : y_cnt_q;
        x_first = (x_cur == '0);
        y_first = (y_cur == '0);
        x_last  = (x_cur == X_LAST);
        y_last  = (y_cur == Y_LAST);
        // Read one column ahead; at the row end this fetches column 0 for the next row's C
        x_rd    = x_last ? '0 : x_cur + X_BITS'(1);
        rd_data = line_mem[x_rd[AW-1:0]];

        x_cnt_d = x_cnt_q;
        y_cnt_d = y_cnt_q;
        left_d  = left_q;
        up_d    = up_q;
        upl_d   = upl_q;
        p_out_d = p_out_q;
        a_out_d = a_out_q;
        b_out_d = b_out_q;
        c_out_d = c_out_q;
        d_out_d = d_out_q;
        q_x_d   = q_x_q;
        q_y_d   = q_y_q;

        q_valid_d    = en;
        frame_done_d = en && x_last && y_last;

        if (en) begin
            if (x_last) begin
                x_cnt_d = '0;
                y_cnt_d = y_last ? '0 : y_cur + Y_BITS'(1);
            end else begin
                x_cnt_d = x_cur + X_BITS'(1);
                y_cnt_d = y_cur;
            end
            left_d  = d;
            up_d    = rd_data;
            upl_d   = up_q;
            p_out_d = d;
            a_out_d = x_first             ? '0 : left_q;
            b_out_d = (x_first || y_first) ? '0 : upl_q;
            c_out_d = y_first             ? '0 : up_q;
            d_out_d = (x_last || y_first)  ? '0 : rd_data;
            q_x_d   = x_cur;
            q_y_d   = y_cur;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            x_cnt_q      <= '0;
            y_cnt_q      <= '0;
            left_q       <= '0;
            up_q         <= '0;
            upl_q        <= '0;
            q_valid_q    <= 1'b0;
            frame_done_q <= 1'b0;
            p_out_q      <= '0;
            a_out_q      <= '0;
            b_out_q      <= '0;
            c_out_q      <= '0;
            d_out_q      <= '0;
            q_x_q        <= '0;
            q_y_q        <= '0;
        end else begin
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            left_q       <= left_d;
            up_q         <= up_d;
            upl_q        <= upl_d;
            q_valid_q    <= q_valid_d;
            frame_done_q <= frame_done_d;
            p_out_q      <= p_out_d;
            a_out_q      <= a_out_d;
            b_out_q      <= b_out_d;
            c_out_q      <= c_out_d;
            d_out_q      <= d_out_d;
            q_x_q        <= q_x_d;
            q_y_q        <= q_y_d;
        end
    end

    // Line buffer write; the read above sees the old contents
    always_ff @(posedge clk) begin
        if (en) begin
            line_mem[x_cur[AW-1:0]] <= d;
        end
    end

    assign q_valid    = q_valid_q;
    assign frame_done = frame_done_q;
    assign P          = p_out_q;
    assign A          = a_out_q;
    assign B          = b_out_q;
    assign C          = c_out_q;
    assign D          = d_out_q;
    assign q_x        = q_x_q;
    assign q_y        = q_y_q;

endmodule

// File: tb/tb_raster_window.sv
// tb_raster_window: directed test of raster_window on a 4x3 image.

module tb_raster_window;

    localparam int WIDTH = 8;
    localparam int IW    = 4;
    localparam int IH    = 3;
    localparam int XB    = 2;
    localparam int YB    = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             en = 1'b0;
    logic             sof = 1'b0;
    logic [WIDTH-1:0] d = '0;
    logic             q_valid;
    logic [WIDTH-1:0] P, A, B, C, D;
    logic [XB-1:0]    q_x;
    logic [YB-1:0]    q_y;
    logic             frame_done;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-computed neighbourhoods for a 4x3 frame carrying values 1..12 (0 = masked)
    int exp_a [12] = '{0, 1, 2, 3,  0, 5, 6,  7,  0, 9, 10, 11};
    int exp_b [12] = '{0, 0, 0, 0,  0, 1, 2,  3,  0, 5,  6,  7};
    int exp_c [12] = '{0, 0, 0, 0,  1, 2, 3,  4,  5, 6,  7,  8};
    int exp_d [12] = '{0, 0, 0, 0,  2, 3, 4,  0,  6, 7,  8,  0};

    raster_window #(
        .WIDTH(WIDTH),
        .IMG_WIDTH(IW),
        .IMG_HEIGHT(IH),
        .X_BITS(XB),
        .Y_BITS(YB)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .sof(sof),
        .d(d),
        .q_valid(q_valid),
        .P(P),
        .A(A),
        .B(B),
        .C(C),
        .D(D),
        .q_x(q_x),
        .q_y(q_y),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic int map(input int t, input int off);
        return (t == 0) ? 0 : t + off;
    endfunction

    // Accept one pixel, then sample one time step after the edge
    task automatic push(input int val, input bit s);
        en  = 1'b1;
        sof = s;
        d   = WIDTH'(val);
        @(posedge clk);
        #1;
        en  = 1'b0;
        sof = 1'b0;
    endtask

    task automatic idle_cycle();
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic check_pix(input string tn, input int k, input int off, input bit fd_allowed);
        check_eq($sformatf("%s k%0d q_valid", tn, k), 32'(q_valid), 32'd1);
        check_eq($sformatf("%s k%0d P", tn, k), 32'(P), 32'(k + 1 + off));
        check_eq($sformatf("%s k%0d A", tn, k), 32'(A), 32'(map(exp_a[k], off)));
        check_eq($sformatf("%s k%0d B", tn, k), 32'(B), 32'(map(exp_b[k], off)));
        check_eq($sformatf("%s k%0d C", tn, k), 32'(C), 32'(map(exp_c[k], off)));
        check_eq($sformatf("%s k%0d D", tn, k), 32'(D), 32'(map(exp_d[k], off)));
        check_eq($sformatf("%s k%0d q_x", tn, k), 32'(q_x), 32'(k % IW));
        check_eq($sformatf("%s k%0d q_y", tn, k), 32'(q_y), 32'(k / IW));
        check_eq($sformatf("%s k%0d frame_done", tn, k), 32'(frame_done),
                 32'((fd_allowed && k == IW * IH - 1) ? 1 : 0));
    endtask

    // Stream pixels off+1 .. off+n, sof on the first; optional idle cycle after each
    task automatic run_frame(input string tn, input int off, input int n, input bit gap);
        for (int k = 0; k < n; k++) begin
            push(k + 1 + off, k == 0);
            check_pix(tn, k, off, 1'b1);
            if (gap) begin
                idle_cycle();
                check_eq($sformatf("%s gap%0d q_valid", tn, k), 32'(q_valid), 32'd0);
                check_eq($sformatf("%s gap%0d frame_done", tn, k), 32'(frame_done), 32'd0);
                check_eq($sformatf("%s gap%0d P hold", tn, k), 32'(P), 32'(k + 1 + off));
                check_eq($sformatf("%s gap%0d A hold", tn, k), 32'(A), 32'(map(exp_a[k], off)));
                check_eq($sformatf("%s gap%0d C hold", tn, k), 32'(C), 32'(map(exp_c[k], off)));
                check_eq($sformatf("%s gap%0d q_x hold", tn, k), 32'(q_x), 32'(k % IW));
            end
        end
    endtask

    task automatic check_all_zero(input string tn);
        check_eq({tn, " q_valid"}, 32'(q_valid), 32'd0);
        check_eq({tn, " P"}, 32'(P), 32'd0);
        check_eq({tn, " A"}, 32'(A), 32'd0);
        check_eq({tn, " B"}, 32'(B), 32'd0);
        check_eq({tn, " C"}, 32'(C), 32'd0);
        check_eq({tn, " D"}, 32'(D), 32'd0);
        check_eq({tn, " q_x"}, 32'(q_x), 32'd0);
        check_eq({tn, " q_y"}, 32'(q_y), 32'd0);
        check_eq({tn, " frame_done"}, 32'(frame_done), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        reset = 1'b0;
        idle_cycle();
        check_all_zero("rst_idle");

        // Frame walk with row-0 masking and frame_done on the last pixel
        run_frame("walk", 0, 12, 1'b0);
        idle_cycle();
        check_eq("walk after q_valid", 32'(q_valid), 32'd0);
        check_eq("walk after frame_done", 32'(frame_done), 32'd0);

        // Gapped enable: same values, spaced q_valid, outputs hold in gaps
        run_frame("gap", 0, 12, 1'b1);

        // Back-to-back frames; second frame row 0 must hide buffered data
        run_frame("b2b1", 0, 12, 1'b0);
        run_frame("b2b2", 100, 12, 1'b0);

        // Mid-frame asynchronous reset after pixel 6
        run_frame("pre_rst", 0, 6, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check_all_zero("midrst async");
        @(posedge clk);
        #1;
        check_all_zero("midrst held");
        reset = 1'b0;
        run_frame("post_rst", 19, 12, 1'b0);

        // Mid-frame sof: 6 pixels, then a new frame begins on the 7th pixel
        run_frame("pre_sof", 0, 6, 1'b0);
        run_frame("resync", 49, 12, 1'b0);
        idle_cycle();
        check_eq("resync end frame_done", 32'(frame_done), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
